// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (double-dabble), one input bit per clock.
// It uses valid/ready handshakes on both sides and reports overflow and a leading-zero mask.
module bcd_seq_converter #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  localparam int CNT_W = $clog2(BIN_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf,
  output logic [DIGITS-1:0]     out_nz_mask,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [BIN_W-1:0]   bin_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic               ovf_reg;
  logic [BCD_W-1:0]   out_bcd_reg;
  logic               out_ovf_reg;

  logic               accept;
  logic               step;
  logic               last_iter;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shift;
  logic               ovf_shift;
  logic [DIGITS-1:0]  digit_nz;
  logic [DIGITS-1:0]  nz_mask_c;

  // Per-digit add-3 correction; digits never carry into each other.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    logic [3:0] digit;
    assign digit               = bcd_reg[4*gi +: 4];
    assign bcd_adj[4*gi +: 4]  = (digit >= 4'd5) ? (digit + 4'd3) : digit;
  end

  // The bit leaving the top digit stands for a multiple of 10^DIGITS, so it only sets ovf.
  assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_reg[BIN_W-1]};
  assign ovf_shift = ovf_reg | bcd_adj[BCD_W-1];
  assign last_iter = (cnt_reg == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      bin_reg     <= '0;
      bcd_reg     <= '0;
      ovf_reg     <= 1'b0;
      out_bcd_reg <= '0;
      out_ovf_reg <= 1'b0;
    end else begin
      if (accept) begin
        bin_reg <= in_bin;
        bcd_reg <= '0;
        ovf_reg <= 1'b0;
        cnt_reg <= '0;
      end else if (step) begin
        bin_reg <= bin_reg << 1;
        bcd_reg <= bcd_shift;
        ovf_reg <= ovf_shift;
        cnt_reg <= cnt_reg + 1'b1;
      end
      // Result registers change only on the final iteration, never with partial data.
      if (step && last_iter) begin
        out_bcd_reg <= bcd_shift;
        out_ovf_reg <= ovf_shift;
      end
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nz
    assign digit_nz[gi] = (out_bcd_reg[4*gi +: 4] != 4'd0);
  end

  // A digit is significant if it or any more significant digit is non-zero; ones always shown.
  always_comb begin
    logic any_nz;
    any_nz    = 1'b0;
    nz_mask_c = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      any_nz       = any_nz | digit_nz[k];
      nz_mask_c[k] = any_nz;
    end
    nz_mask_c[0] = 1'b1;
  end

  assign in_ready    = (state_reg == IDLE);
  assign busy        = (state_reg == SHIFT);
  assign out_valid   = (state_reg == DONE);
  assign out_bcd     = out_bcd_reg;
  assign out_ovf     = out_ovf_reg;
  assign out_nz_mask = nz_mask_c;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter: three parameterisations share one stimulus/monitor path.
// The stimulus pushes the expected results into a queue, and the monitor pops them at each output handshake.
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_bin;
  logic [1:0]  sel;

  always #5 clk = ~clk;

  // DUT A: defaults (16 bits, 5 digits)
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_ovf_a, busy_a;
  logic [19:0] out_bcd_a;
  logic [4:0]  mask_a;
  // DUT B: 16 bits, 4 digits
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_ovf_b, busy_b;
  logic [15:0] out_bcd_b;
  logic [3:0]  mask_b;
  // DUT C: 8 bits, 3 digits
  logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c, out_ovf_c, busy_c;
  logic [11:0] out_bcd_c;
  logic [2:0]  mask_c;

  assign in_valid_a  = in_valid  && (sel == 2'd0);
  assign in_valid_b  = in_valid  && (sel == 2'd1);
  assign in_valid_c  = in_valid  && (sel == 2'd2);
  assign out_ready_a = out_ready && (sel == 2'd0);
  assign out_ready_b = out_ready && (sel == 2'd1);
  assign out_ready_c = out_ready && (sel == 2'd2);

  bcd_seq_converter #(.BIN_W(16), .DIGITS(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_bin(in_bin),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_bcd(out_bcd_a), .out_ovf(out_ovf_a),
    .out_nz_mask(mask_a), .busy(busy_a)
  );

  bcd_seq_converter #(.BIN_W(16), .DIGITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_bin(in_bin),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_bcd(out_bcd_b), .out_ovf(out_ovf_b),
    .out_nz_mask(mask_b), .busy(busy_b)
  );

  bcd_seq_converter #(.BIN_W(8), .DIGITS(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c), .in_bin(in_bin[7:0]),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .out_bcd(out_bcd_c), .out_ovf(out_ovf_c),
    .out_nz_mask(mask_c), .busy(busy_c)
  );

  // Selected DUT view, zero-extended to the widest shape
  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_ovf;
  logic [19:0] m_bcd;
  logic [4:0]  m_mask;
  int          m_bw;

  always_comb begin
    m_in_valid  = in_valid;
    m_out_ready = out_ready;
    m_in_ready  = in_ready_a;
    m_out_valid = out_valid_a;
    m_ovf       = out_ovf_a;
    m_bcd       = out_bcd_a;
    m_mask      = mask_a;
    m_bw        = 16;
    if (sel == 2'd1) begin
      m_in_ready  = in_ready_b;
      m_out_valid = out_valid_b;
      m_ovf       = out_ovf_b;
      m_bcd       = {4'h0, out_bcd_b};
      m_mask      = {1'b0, mask_b};
    end else if (sel == 2'd2) begin
      m_in_ready  = in_ready_c;
      m_out_valid = out_valid_c;
      m_ovf       = out_ovf_c;
      m_bcd       = {8'h00, out_bcd_c};
      m_mask      = {2'b00, mask_c};
      m_bw        = 8;
    end
  end

  typedef struct packed {
    logic [19:0] bcd;
    logic        ovf;
    logic [4:0]  mask;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: latency from accept to out_valid rise, and result contents at each handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      prev_valid <= 1'b0;
    end else begin
      if (m_in_valid && m_in_ready) acc_q.push_back(cyc + 1);
      if (m_out_valid && !prev_valid) begin
        if (acc_q.size() == 0) begin
          chk("valid_without_accept", 32'd1, 32'd0);
        end else begin
          automatic int a = acc_q.pop_front();
          chk("latency", 32'(cyc - a), 32'(m_bw));
        end
      end
      if (m_out_valid && m_out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          automatic exp_t e = exp_q.pop_front();
          $display("txn dut=%0d bcd=%05h ovf=%b mask=%05b", sel, m_bcd, m_ovf, m_mask);
          chk("out_bcd", 32'(m_bcd), 32'(e.bcd));
          chk("out_ovf", 32'(m_ovf), 32'(e.ovf));
          chk("out_nz_mask", 32'(m_mask), 32'(e.mask));
        end
      end
      prev_valid <= m_out_valid;
    end
  end

  task automatic send(input logic [15:0] v, input logic [19:0] b, input logic o,
                      input logic [4:0] m, input bit push);
    int n = 0;
    while (!m_in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_ready_timeout", 32'(m_in_ready), 32'd1);
    if (push) exp_q.push_back({b, o, m});
    in_bin   = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("result_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int a1, a2, n;
    logic [19:0] eb;
    logic [4:0]  em;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_bin    = '0;
    sel       = 2'd0;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", 32'(in_ready_a), 32'd1);
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_out_bcd", 32'(out_bcd_a), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf_a), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero input
    send(16'd0, 20'h00000, 1'b0, 5'b00001, 1'b1);
    drain();

    // Back-to-back with in_valid held high
    exp_q.push_back({20'h65535, 1'b0, 5'b11111});
    in_bin   = 16'd65535;
    in_valid = 1'b1;
    @(posedge clk); #1;
    a1 = cyc;
    in_bin = 16'd255;
    exp_q.push_back({20'h00255, 1'b0, 5'b00111});
    n = 0;
    while (!m_in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    a2 = cyc;
    in_valid = 1'b0;
    chk("b2b_period", 32'(a2 - a1), 32'd18);
    drain();

    // Backpressure: result held, new request ignored
    out_ready = 1'b0;
    send(16'd1234, 20'h01234, 1'b0, 5'b01111, 1'b1);
    n = 0;
    while (!out_valid_a && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid_seen", 32'(out_valid_a), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_bcd", 32'(out_bcd_a), 32'h01234);
      chk("bp_in_ready", 32'(in_ready_a), 32'd0);
      in_valid = (i == 4);
      in_bin   = 16'd7;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", 32'(in_ready_a), 32'd1);
    chk("bp_release_valid", 32'(out_valid_a), 32'd0);

    // Asynchronous reset mid-conversion
    send(16'd4321, 20'h0, 1'b0, 5'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_busy", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_in_ready", 32'(in_ready_a), 32'd1);
    chk("arst_out_valid", 32'(out_valid_a), 32'd0);
    chk("arst_out_bcd", 32'(out_bcd_a), 32'd0);
    chk("arst_out_ovf", 32'(out_ovf_a), 32'd0);
    chk("arst_mask", 32'(mask_a), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'd42, 20'h00042, 1'b0, 5'b00011, 1'b1);
    drain();

    // Four-digit instance: overflow boundary
    sel = 2'd1;
    @(posedge clk); #1;
    send(16'd9999,  20'h09999, 1'b0, 5'b01111, 1'b1);
    drain();
    send(16'd10000, 20'h00000, 1'b1, 5'b00001, 1'b1);
    drain();
    send(16'd12345, 20'h02345, 1'b1, 5'b01111, 1'b1);
    drain();

    // Eight-bit instance: full sweep against decimal digit extraction
    sel = 2'd2;
    @(posedge clk); #1;
    for (int v = 0; v < 256; v++) begin
      eb = {8'h00, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      em = {2'b00, (v >= 100), (v >= 10), 1'b1};
      send(16'(v), eb, 1'b0, em, 1'b1);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
